nios2_pio_in_edge: RTL and testbench

- Parametrised Avalon-MM input PIO for the Nios II subsystem, used to read audio AGC status/data lines.
- Synchronises an asynchronous DATA_WIDTH-bit input bus and exposes the sampled value as a readable register.
- Adds per-bit edge capture, an interrupt mask, and a level- or edge-mode IRQ to the Nios II.

---
 rtl/nios2_pio_in_edge.sv | 143 ++++++++++++++
 tb/tb_nios2_pio_in_edge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_pio_in_edge.sv
// rtl/nios2_pio_in_edge.sv - Avalon-MM input PIO with synchroniser, edge capture and IRQ
//
// Reads a DATA_WIDTH-bit asynchronous input bus through a SYNC_STAGES-deep
// synchroniser. Per-bit edges are latched in edgecapture (write-1-to-clear).
// A maskable interrupt is raised from edgecapture or from the sampled level.
//
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   address    - register select (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   in_port    - asynchronous external inputs
//   readdata   - registered read data (1-cycle latency, address-driven)
//   irq        - registered interrupt request

module nios2_pio_in_edge #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [2:0] ARM_INIT = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] edgecapture;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] ec_clear;
  logic [2:0]            arm_cnt;
  logic                  wr_en;
  logic                  irq_src;
  logic [31:0]           rd_mux;

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign wr_en   = chipselect & ~write_n;

  // Upper write-data bits beyond the register width are intentionally ignored.
  if (DATA_WIDTH < 32) begin : g_wdata_pad
    logic unused_wdata;
    assign unused_wdata = &writedata[31:DATA_WIDTH];
  end

  // Synchroniser chain plus one extra register holding the previous sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev <= sync_in;
    end
  end

  // Arming counter: holds edge detection off until the synchroniser and prev
  // register have been filled with real input samples after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= ARM_INIT;
    end else if (arm_cnt != 3'd0) begin
      arm_cnt <= arm_cnt - 3'd1;
    end
  end

  always_comb begin
    edge_det = '0;
    if (arm_cnt == 3'd0) begin
      case (EDGE_TYPE)
        0:       edge_det = sync_in & ~prev;
        1:       edge_det = ~sync_in & prev;
        default: edge_det = sync_in ^ prev;
      endcase
    end
  end

  assign ec_clear = (wr_en && (address == 2'd3)) ? writedata[DATA_WIDTH-1:0] : '0;

  // Set has priority over a simultaneous write-1-to-clear on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~ec_clear) | edge_det;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_en && (address == 2'd2)) begin
      irqmask <= writedata[DATA_WIDTH-1:0];
    end
  end

  assign irq_src = (IRQ_MODE == 1) ? |(sync_in & irqmask) : |(edgecapture & irqmask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_src;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[DATA_WIDTH-1:0] = sync_in;
      2'd2:    rd_mux[DATA_WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[DATA_WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  // Read data is registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_nios2_pio_in_edge.sv
// tb/tb_nios2_pio_in_edge.sv - self-checking bench for nios2_pio_in_edge

module tb_nios2_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;

  logic [15:0] in0 = '0, in1 = '0, in2 = '0;
  logic [7:0]  in3 = '0;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int checks = 0;
  int fails = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  nios2_pio_in_edge u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0)
  );

  nios2_pio_in_edge #(.EDGE_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1)
  );

  nios2_pio_in_edge #(.IRQ_MODE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2)
  );

  nios2_pio_in_edge #(.DATA_WIDTH(8)) u3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in3), .readdata(rd3), .irq(irq3)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in0 = 16'hA5A5;
    reset_n = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    tick(2);
    exp = exp_q.pop_front(); checks++;
    if (rd0 !== exp) begin fails++; $display("FAIL reset_readdata got %h want %h", rd0, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq0} !== exp) begin fails++; $display("FAIL reset_irq got %b want %h", irq0, exp); end
    reset_n = 1'b1;
    bus_write(2'd2, 32'h0000_FFFF);
    exp_q.push_back(32'h0000_A5A5);
    address = 2'd0;
    tick(3);
    exp = exp_q.pop_front(); checks++;
    if (rd0 !== exp) begin fails++; $display("FAIL reset_data_read got %h want %h", rd0, exp); end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    bus_read(2'd3);
    tick(3);
    exp = exp_q.pop_front(); checks++;
    if (rd0 !== exp) begin fails++; $display("FAIL arm_no_spurious_edge got %h want %h", rd0, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq0} !== exp) begin fails++; $display("FAIL arm_irq got %b want %h", irq0, exp); end
  endtask

  task automatic test_rising_edge_irq();
    in0 = '0;
    apply_reset();
    tick(6);
    bus_write(2'd2, 32'h0000_0001);
    address = 2'd3;
    in0 = 16'h0001;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    tick(3);
    exp = exp_q.pop_front(); checks++;
    if (rd0 !== exp) begin fails++; $display("FAIL edge_early_rd got %h want %h", rd0, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq0} !== exp) begin fails++; $display("FAIL edge_early_irq got %b want %h", irq0, exp); end
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    tick(1);
    exp = exp_q.pop_front(); checks++;
    if (rd0 !== exp) begin fails++; $display("FAIL edge_capture got %h want %h", rd0, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq0} !== exp) begin fails++; $display("FAIL edge_irq got %b want %h", irq0, exp); end
    bus_write(2'd3, 32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    tick(1);
    exp = exp_q.pop_front(); checks++;
    if (rd0 !== exp) begin fails++; $display("FAIL w1c_clear got %h want %h", rd0, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq0} !== exp) begin fails++; $display("FAIL w1c_irq got %b want %h", irq0, exp); end
  endtask

  task automatic test_falling_edge();
    in1 = '0;
    apply_reset();
    tick(6);
    in1 = 16'hFFFF;
    tick(4);
    in1 = 16'h00F0;
    tick(4);
    exp_q.push_back(32'h0000_FF0F);
    bus_read(2'd3);
    exp = exp_q.pop_front(); checks++;
    if (rd1 !== exp) begin fails++; $display("FAIL falling_capture got %h want %h", rd1, exp); end
    bus_write(2'd3, 32'h0000_000F);
    exp_q.push_back(32'h0000_FF00);
    bus_read(2'd3);
    exp = exp_q.pop_front(); checks++;
    if (rd1 !== exp) begin fails++; $display("FAIL falling_partial_clear got %h want %h", rd1, exp); end
  endtask

  task automatic test_set_clear_collision();
    in0 = '0;
    apply_reset();
    tick(6);
    in0 = 16'h0008;
    tick(2);
    bus_write(2'd3, 32'h8);
    exp_q.push_back(32'h8);
    bus_read(2'd3);
    exp = exp_q.pop_front(); checks++;
    if (rd0 !== exp) begin fails++; $display("FAIL set_beats_clear got %h want %h", rd0, exp); end
    bus_write(2'd3, 32'h8);
    exp_q.push_back(32'h0);
    bus_read(2'd3);
    exp = exp_q.pop_front(); checks++;
    if (rd0 !== exp) begin fails++; $display("FAIL later_clear got %h want %h", rd0, exp); end
  endtask

  task automatic test_level_irq();
    in2 = '0;
    apply_reset();
    tick(6);
    bus_write(2'd2, 32'h0000_0100);
    in2 = 16'h0100;
    exp_q.push_back(32'h1);
    tick(3);
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq2} !== exp) begin fails++; $display("FAIL level_irq_high got %b want %h", irq2, exp); end
    in2 = 16'h0000;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    tick(2);
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq2} !== exp) begin fails++; $display("FAIL level_irq_hold got %b want %h", irq2, exp); end
    tick(1);
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq2} !== exp) begin fails++; $display("FAIL level_irq_low got %b want %h", irq2, exp); end
    in2 = 16'h1234;
    tick(4);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0100);
    bus_read(2'd0);
    exp = exp_q.pop_front(); checks++;
    if (rd2 !== exp) begin fails++; $display("FAIL ro_data got %h want %h", rd2, exp); end
    bus_read(2'd1);
    exp = exp_q.pop_front(); checks++;
    if (rd2 !== exp) begin fails++; $display("FAIL reserved got %h want %h", rd2, exp); end
    bus_read(2'd2);
    exp = exp_q.pop_front(); checks++;
    if (rd2 !== exp) begin fails++; $display("FAIL mask_unchanged got %h want %h", rd2, exp); end
    address = 2'd2;
    chipselect = 1'b0;
    write_n = 1'b0;
    writedata = 32'h0000_FFFF;
    tick(1);
    write_n = 1'b1;
    chipselect = 1'b1;
    tick(1);
    chipselect = 1'b0;
    exp_q.push_back(32'h0000_0100);
    bus_read(2'd2);
    exp = exp_q.pop_front(); checks++;
    if (rd2 !== exp) begin fails++; $display("FAIL gated_write got %h want %h", rd2, exp); end
  endtask

  task automatic test_narrow_and_async_reset();
    in3 = '0;
    apply_reset();
    tick(6);
    bus_write(2'd2, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF);
    bus_read(2'd2);
    exp = exp_q.pop_front(); checks++;
    if (rd3 !== exp) begin fails++; $display("FAIL narrow_mask got %h want %h", rd3, exp); end
    in3 = 8'hFF;
    tick(5);
    exp_q.push_back(32'h1);
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq3} !== exp) begin fails++; $display("FAIL narrow_irq got %b want %h", irq3, exp); end
    address = 2'd2;
    writedata = 32'h0000_00AA;
    chipselect = 1'b1;
    write_n = 1'b0;
    in3 = 8'h00;
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if (rd3 !== exp) begin fails++; $display("FAIL async_reset_rd got %h want %h", rd3, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'b0, irq3} !== exp) begin fails++; $display("FAIL async_reset_irq got %b want %h", irq3, exp); end
    chipselect = 1'b0;
    write_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(32'h0);
      bus_read(2'(a));
      exp = exp_q.pop_front(); checks++;
      if (rd3 !== exp) begin fails++; $display("FAIL post_reset_addr%0d got %h want %h", a, rd3, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_rising_edge_irq();
    test_falling_edge();
    test_set_clear_collision();
    test_level_irq();
    test_narrow_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
